iiitb_freqdiv_multi: RTL

//  Multi-channel programmable clock divider; parametrised successor of the single-channel 4-bit divider.
//  CH independent channels, each dividing wb_clk_i by a WIDTH-bit ratio with programmable high time.

---
 rtl/iiitb_freqdiv_multi_if.sv | 29 ++
 rtl/iiitb_freqdiv_multi.sv | 126 ++++++++++++
 2 files changed

// File: rtl/iiitb_freqdiv_multi_if.sv
// rtl/iiitb_freqdiv_multi_if.sv - configuration bus of the multi-channel clock divider
// The master is the register writer; the divider drives back which channels hold an unapplied shadow.
interface iiitb_freqdiv_multi_if #(
  parameter int CH    = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
);
  logic             cfg_we;
  logic [SELW-1:0]  cfg_sel;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;
  logic [CH-1:0]    cfg_pending;

  modport master (
    output cfg_we,
    output cfg_sel,
    output cfg_div,
    output cfg_high,
    input  cfg_pending
  );

  modport slave (
    input  cfg_we,
    input  cfg_sel,
    input  cfg_div,
    input  cfg_high,
    output cfg_pending
  );
endinterface

// File: rtl/iiitb_freqdiv_multi.sv
// rtl/iiitb_freqdiv_multi.sv - multi-channel programmable clock divider with shadowed config
// Each channel divides wb_clk_i by div and reloads its config only at period boundaries or while idle.
module iiitb_freqdiv_multi #(
  parameter int CH    = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  iiitb_freqdiv_multi_if.slave   cfg,
  input  logic [CH-1:0]          en,
  output logic [CH-1:0]          clk_out,
  output logic [CH-1:0]          tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // high == 0 selects floor(div/2); anything at or beyond div is clamped so the output still toggles
  function automatic logic [WIDTH-1:0] high_eff(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] h);
    if (h == '0) begin
      return d >> 1;
    end else if (h >= d) begin
      return d - ONE;
    end else begin
      return h;
    end
  endfunction

  logic [CH-1:0] pend_v;

  assign cfg.cfg_pending = pend_v;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t           st_q, st_d;
    logic [WIDTH-1:0] div_s_q, high_s_q;
    logic [WIDTH-1:0] div_a_q, high_a_q, div_a_d, high_a_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit, load, wrap;

    // an out-of-range cfg_sel matches no channel, so such writes fall on the floor
    assign wr_hit = cfg.cfg_we && (cfg.cfg_sel == SELW'(c));
    assign wrap   = (cnt_q == (div_a_q - ONE));

    always_comb begin
      st_d     = st_q;
      div_a_d  = div_a_q;
      high_a_d = high_a_q;
      cnt_d    = cnt_q;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      load     = 1'b0;

      case (st_q)
        ST_IDLE: load = 1'b1;
        ST_RUN: begin
          if (!en[c] || wrap) begin
            load = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
            clk_d = (cnt_d < high_eff(div_a_q, high_a_q));
          end
        end
        default: load = 1'b1;
      endcase

      // boundary: the pre-edge shadow becomes active and a fresh period may start at cnt 0
      if (load) begin
        div_a_d  = div_s_q;
        high_a_d = high_s_q;
        cnt_d    = '0;
        if (en[c] && (div_s_q >= TWO)) begin
          st_d   = ST_RUN;
          tick_d = 1'b1;
          clk_d  = (high_eff(div_s_q, high_s_q) != '0);
        end else begin
          st_d   = ST_IDLE;
        end
      end

      if (wr_hit) begin
        pend_d = 1'b1;
      end else if (load) begin
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        st_q     <= ST_IDLE;
        div_s_q  <= '0;
        high_s_q <= '0;
        div_a_q  <= '0;
        high_a_q <= '0;
        cnt_q    <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        st_q     <= st_d;
        div_a_q  <= div_a_d;
        high_a_q <= high_a_d;
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        if (wr_hit) begin
          div_s_q  <= cfg.cfg_div;
          high_s_q <= cfg.cfg_high;
        end
      end
    end

    assign clk_out[c] = clk_q;
    assign tick[c]    = tick_q;
    assign pend_v[c]  = pend_q;
  end

endmodule
